// File: rtl/ripple_carry_adder_64bit_if.sv
// rtl/ripple_carry_adder_64bit_if.sv - operand/result bundle for the ripple-carry adder
// The sub port appears only when RCA_SUB_EN is defined.
interface ripple_carry_adder_64bit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
`ifdef RCA_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             out_valid;

`ifdef RCA_SUB_EN
  modport master (
    output in_valid, in1, in2, c_in, sub,
    input  sum, c_out, overflow, out_valid
  );
  modport slave (
    input  in_valid, in1, in2, c_in, sub,
    output sum, c_out, overflow, out_valid
  );
`else
  modport master (
    output in_valid, in1, in2, c_in,
    input  sum, c_out, overflow, out_valid
  );
  modport slave (
    input  in_valid, in1, in2, c_in,
    output sum, c_out, overflow, out_valid
  );
`endif
endinterface

// File: rtl/ripple_carry_adder_64bit.sv
// rtl/ripple_carry_adder_64bit.sv - registered ripple-carry adder with carry-out and signed overflow
// Optional RCA_SUB_EN adds a sub input that inverts in2 ahead of the carry chain.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder_64bit #(
  parameter int WIDTH = 64
) (
  input logic                          clk,
  input logic                          rst_n,
  ripple_carry_adder_64bit_if.slave    bus
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

`ifdef RCA_SUB_EN
  assign b_eff = bus.in2 ^ {WIDTH{bus.sub}};
`else
  assign b_eff = bus.in2;
`endif

  assign c[0] = bus.c_in;

  // Pure ripple: each cell's carry-out is the next cell's carry-in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    rca_full_adder u_fa (
      .a  (bus.in1[i]),
      .b  (b_eff[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.c_out     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum      <= s;
        bus.c_out    <= c[WIDTH];
        bus.overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder_64bit.sv
// tb/tb_ripple_carry_adder_64bit.sv - scoreboard bench for ripple_carry_adder_64bit
// Directed vectors; define RCA_SUB_EN to also exercise subtraction.
module tb_ripple_carry_adder_64bit;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];

  ripple_carry_adder_64bit_if #(.WIDTH(W)) bus ();

  ripple_carry_adder_64bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string name, input logic [W-1:0] s, input logic co,
                               input logic ov, input logic ovld);
    check(name, {bus.out_valid, bus.c_out, bus.overflow, bus.sum[W-2:0]},
                {ovld, co, ov, s[W-2:0]});
    check({name, "_msb"}, {{W{1'b0}}, bus.sum[W-1], bus.out_valid}, {{W{1'b0}}, s[W-1], ovld});
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb, input logic [W-1:0] es, input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1      = a;
    bus.in2      = b;
    bus.c_in     = ci;
`ifdef RCA_SUB_EN
    bus.sub      = sb;
`endif
    e.sum = es;
    e.co  = eco;
    e.ov  = eov;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in1      = 'x;
    bus.in2      = 'x;
    bus.c_in     = 1'bx;
`ifdef RCA_SUB_EN
    bus.sub      = 1'bx;
`endif
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got sum=%h c_out=%b, expected no result", bus.sum, bus.c_out);
      end else begin
        e = exp_q.pop_front();
        check("result", {1'b0, bus.c_out, bus.overflow, bus.sum[W-1:1]},
                        {1'b0, e.co, e.ov, e.sum[W-1:1]});
        check("result_lsb", {{W+1{1'b0}}, bus.sum[0]}, {{W+1{1'b0}}, e.sum[0]});
      end
    end
  end

  initial begin
    int waited;
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.c_in      = 1'b0;
`ifdef RCA_SUB_EN
    bus.sub       = 1'b0;
`endif

    // Reset held for three cycles with random stimulus
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in1      = {$urandom, $urandom};
      bus.in2      = {$urandom, $urandom};
      bus.c_in     = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs("reset_hold", '0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // Single add, then hold
    issue(64'd12765438912345, 64'd98345672198765, 1'b0, 1'b0, 64'd111111111111110, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_outputs("hold_after_idle", 64'd111111111111110, 1'b0, 1'b0, 1'b0);

    // Wrap and signed overflow boundaries
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check_outputs("hold_overflow", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream
    issue(64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);
    issue(64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0, 1'b0);
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    idle();

    // Asynchronous reset right after a captured result, with valid still asserted
    issue(64'd20, 64'd22, 1'b0, 1'b0, 64'd42, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset_clear", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("reset_ignores_valid", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("no_stale_after_release", '0, 1'b0, 1'b0, 1'b0);

`ifdef RCA_SUB_EN
    issue(64'd100, 64'd58, 1'b1, 1'b1, 64'd42, 1'b1, 1'b0);
    issue(64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    idle();
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder_64bit.md
Name: ripple_carry_adder_64bit

Overview:
- Registered 64-bit ripple-carry adder: sum = in1 + in2 + c_in, with carry-out and signed-overflow flags.
- Datapath is a structural chain of WIDTH one-bit full-adder cells; each cell's carry feeds the next.
- Results are captured in an output register one clock after a valid input.
- Used as the integer add datapath primitive in the arithmetic unit; also the reference block for adder-delay characterisation.

Parameters:
- WIDTH, 64, operand and sum width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high = in1/in2/c_in are valid this cycle; capture the result.
- in1  input  WIDTH  operand A, unsigned or two's complement.
- in2  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  registered result bits [WIDTH-1:0].
- c_out  output  1  registered carry out of bit WIDTH-1 (unsigned overflow).
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  high for one cycle when sum/c_out/overflow hold a new result.

Behaviour:
- Combinational core:
  - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = c_in.
  - Chain built with a generate loop of full-adder cells. No lookahead; ripple topology is required.
- Arithmetic is modulo 2^WIDTH. The (WIDTH+1)-bit result equals {c_out, sum}.
- Latency: in_valid=1 at edge N puts the result on the outputs after edge N, with out_valid=1 for exactly that cycle.
- Back-to-back in_valid on every cycle gives one result per cycle. There is no backpressure and no stall input.
- in_valid=0 at an edge:
  - sum, c_out and overflow hold their previous values.
  - out_valid goes to 0.
- Reset:
  - rst_n low immediately forces sum=0, c_out=0, overflow=0, out_valid=0, independent of clk.
  - Outputs stay at these values while rst_n is low; in_valid is ignored.
  - Reset mid-stream discards any in-flight result. The first capture after release is the first edge with rst_n=1 and in_valid=1.
- Boundary cases:
  - All-ones + 0 with c_in=1 wraps to 0 with c_out=1.
  - Maximum positive + 1 sets overflow=1 and c_out=0.
  - X/Z on the inputs when in_valid=0 must not change the outputs.
- Output values must match the synthesised behaviour exactly. There are no internal delay annotations.

Optional Feature:
- Macro: RCA_SUB_EN.
- Defined:
  - Adds input port sub (1 bit).
  - When sub=1, in2 is bitwise inverted before the chain, so result = in1 + ~in2 + c_in. With c_in=1 this is in1 - in2.
  - c_out=1 means no borrow; overflow uses the same MSB carry rule.
  - sub is sampled with in_valid.
- Undefined: no sub port; always add.

Test Plan:
1. Reset with rst_n=0 for 3 cycles while driving random inputs -> sum=0, c_out=0, overflow=0, out_valid=0 throughout.
2. in1=64'd12765438912345, in2=64'd98345672198765, c_in=0, in_valid=1 for one cycle -> next cycle sum=64'd111111111111110, c_out=0, overflow=0, out_valid=1; following cycle out_valid=0 and sum held.
3. in1=64'hFFFF_FFFF_FFFF_FFFF, in2=0, c_in=1 -> sum=0, c_out=1, overflow=0. Then in1=64'h7FFF_FFFF_FFFF_FFFF, in2=1, c_in=0 -> sum=64'h8000_0000_0000_0000, c_out=0, overflow=1.
4. Back-to-back valids (0+0+1, then 5+7+0, then 64'hAAAA_AAAA_AAAA_AAAA+64'h5555_5555_5555_5555+1) -> sums 1, 12, 0 on three consecutive cycles; the last has c_out=1.
5. Assert rst_n=0 asynchronously between clock edges right after a valid input -> outputs clear immediately; no stale result appears after release.
6. With RCA_SUB_EN defined: sub=1, in1=100, in2=58, c_in=1 -> sum=42, c_out=1. Then sub=1, in1=0, in2=1, c_in=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, c_out=0.
